arbitro_memoria_dados: RTL and testbench

Two-port arbiter that shares the single 128×32 data memory between the single-cycle core and a host/debug port. Host traffic includes loader, monitor and DMA writes. The core has priority and keeps its combinational, zero-latency access. The host is served in cycles where the core does not touch memory. If the host has waited `STARVE_LIMIT` cycles, the arbiter steals one core cycle by asserting `core_stall`.

---
 rtl/arbitro_pkg.sv | 11 +
 rtl/contador_saturado.sv | 26 ++
 rtl/arbitro_memoria_dados.sv | 116 +++++++++++
 tb/tb_arbitro_memoria_dados.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/arbitro_pkg.sv
// Shared constants for the data-memory arbiter: default widths and FSM state encodings.
package arbitro_pkg;

  localparam int unsigned ADDR_WIDTH = 7;
  localparam int unsigned DATA_WIDTH = 32;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_WAIT  = 2'd1;
  localparam logic [1:0] ARB_STEAL = 2'd2;

endpackage

// File: rtl/contador_saturado.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
module contador_saturado #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/arbitro_memoria_dados.sv
// Shares the data memory between the core (priority, zero latency) and a host port;
// a starved host steals one core cycle via core_stall.
module arbitro_memoria_dados #(
  parameter int unsigned DATA_WIDTH   = arbitro_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH   = arbitro_pkg::ADDR_WIDTH,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  input  logic                  core_we,
  input  logic                  core_re,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_stall,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_gnt,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_rvalid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]  conflict_cnt
);
  import arbitro_pkg::*;

  localparam logic [7:0] Limit = 8'(STARVE_LIMIT);

  logic [1:0]            state_q, state_d;
  logic [7:0]            wait_cnt_q, wait_cnt_d;
  logic [DATA_WIDTH-1:0] host_rdata_q;
  logic                  host_rvalid_q;
  logic                  core_active, steal, denial;

  assign core_active = core_re | core_we;
  assign steal       = (state_q == ARB_STEAL);
  assign host_gnt    = host_req & (~core_active | steal);
  assign core_stall  = steal & host_req;
  assign denial      = host_req & core_active & ~steal;

  always_comb begin
    mem_addr   = core_addr;
    mem_wdata  = core_wdata;
    mem_we     = core_we;
    mem_re     = core_re;
    core_rdata = mem_rdata;
    if (host_gnt) begin
      mem_addr   = host_addr;
      mem_wdata  = host_wdata;
      mem_we     = host_we;
      mem_re     = ~host_we;
      core_rdata = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (denial) begin
          wait_cnt_d = 8'd1;
          state_d    = (Limit == 8'd1) ? ARB_STEAL : ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (denial) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_d == Limit) state_d = ARB_STEAL;
        end else begin
          // Not denied in WAIT means either granted or the request went away.
          wait_cnt_d = 8'd0;
          state_d    = ARB_IDLE;
        end
      end
      default: begin
        wait_cnt_d = 8'd0;
        state_d    = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ARB_IDLE;
      wait_cnt_q    <= 8'd0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      host_rvalid_q <= host_gnt & ~host_we;
      if (host_gnt && !host_we) host_rdata_q <= mem_rdata;
    end
  end

  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;

  contador_saturado #(
    .WIDTH(CNT_WIDTH)
  ) u_conflitos (
    .clk  (clk),
    .reset(reset),
    .inc  (denial),
    .clr  (1'b0),
    .count(conflict_cnt)
  );

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// Directed bench for arbitro_memoria_dados: one instance at STARVE_LIMIT=4 with a behavioural
// memory, a second at STARVE_LIMIT=255 for conflict counter saturation.
module tb_arbitro_memoria_dados;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Main instance signals
  logic [6:0]  core_addr, host_addr, mem_addr;
  logic [31:0] core_wdata, host_wdata, mem_wdata, core_rdata, host_rdata, mem_rdata;
  logic        core_we, core_re, core_stall, host_req, host_we, host_gnt, host_rvalid;
  logic        mem_we, mem_re;
  logic [15:0] conflict_cnt;

  // Saturation instance signals
  logic [6:0]  s_core_addr, s_host_addr, s_mem_addr;
  logic [31:0] s_core_wdata, s_host_wdata, s_mem_wdata, s_core_rdata, s_host_rdata;
  logic        s_core_we, s_core_re, s_core_stall, s_host_req, s_host_we, s_host_gnt;
  logic        s_host_rvalid, s_mem_we, s_mem_re;
  logic [15:0] s_conflict_cnt;

  logic [31:0] mem [128];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  arbitro_memoria_dados #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_we(core_we), .core_re(core_re),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  arbitro_memoria_dados #(.STARVE_LIMIT(255)) dut_sat (
    .clk(clk), .reset(reset),
    .core_addr(s_core_addr), .core_wdata(s_core_wdata), .core_we(s_core_we),
    .core_re(s_core_re), .core_rdata(s_core_rdata), .core_stall(s_core_stall),
    .host_req(s_host_req), .host_we(s_host_we), .host_addr(s_host_addr),
    .host_wdata(s_host_wdata), .host_gnt(s_host_gnt), .host_rdata(s_host_rdata),
    .host_rvalid(s_host_rvalid), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_we(s_mem_we), .mem_re(s_mem_re), .mem_rdata(32'h0), .conflict_cnt(s_conflict_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then driven, checks happen at negedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_addr = '0; core_wdata = '0; core_we = 1'b0; core_re = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    idle_inputs();
    s_core_addr = '0; s_core_wdata = '0; s_core_we = 1'b0; s_core_re = 1'b0;
    s_host_req = 1'b0; s_host_we = 1'b1; s_host_addr = 7'd3; s_host_wdata = 32'h1;
    reset = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check_eq("rst_gnt", {31'b0, host_gnt}, 32'h0);
    check_eq("rst_rvalid", {31'b0, host_rvalid}, 32'h0);
    check_eq("rst_rdata", host_rdata, 32'h0);
    check_eq("rst_stall", {31'b0, core_stall}, 32'h0);
    check_eq("rst_cnt", {16'b0, conflict_cnt}, 32'h0);
    reset = 1'b1;
    tick();

    // Host write with core idle: granted same cycle
    host_req = 1'b1; host_we = 1'b1; host_addr = 7'd5; host_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check_eq("hw_gnt", {31'b0, host_gnt}, 32'h1);
    check_eq("hw_mem_we", {31'b0, mem_we}, 32'h1);
    tick();
    idle_inputs();
    check_eq("hw_commit", mem[5], 32'hDEADBEEF);

    // Host read: rvalid one cycle after grant, for exactly one cycle
    host_req = 1'b1; host_we = 1'b0; host_addr = 7'd5;
    @(negedge clk);
    check_eq("hr_gnt", {31'b0, host_gnt}, 32'h1);
    check_eq("hr_rvalid_early", {31'b0, host_rvalid}, 32'h0);
    tick();
    idle_inputs();
    @(negedge clk);
    check_eq("hr_rvalid", {31'b0, host_rvalid}, 32'h1);
    check_eq("hr_rdata", host_rdata, 32'hDEADBEEF);
    tick();
    @(negedge clk);
    check_eq("hr_rvalid_drop", {31'b0, host_rvalid}, 32'h0);

    // Core loads with host idle: zero latency, no stall or grant
    core_re = 1'b1; core_addr = 7'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("core_rdata", core_rdata, 32'hDEADBEEF);
      check_eq("core_nostall", {31'b0, core_stall}, 32'h0);
      check_eq("core_nognt", {31'b0, host_gnt}, 32'h0);
      tick();
    end
    check_eq("core_cnt", {16'b0, conflict_cnt}, 32'h0);

    // Starvation: 4 denials, then steal, then core free again
    core_re = 1'b1; core_addr = 7'd0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 7'd20; host_wdata = 32'hA5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("starve_deny_gnt", {31'b0, host_gnt}, 32'h0);
      check_eq("starve_deny_stall", {31'b0, core_stall}, 32'h0);
      tick();
    end
    @(negedge clk);
    check_eq("steal_stall", {31'b0, core_stall}, 32'h1);
    check_eq("steal_gnt", {31'b0, host_gnt}, 32'h1);
    tick();
    host_req = 1'b0;
    @(negedge clk);
    check_eq("post_steal_stall", {31'b0, core_stall}, 32'h0);
    check_eq("starve_cnt", {16'b0, conflict_cnt}, 32'd4);
    check_eq("steal_write", mem[20], 32'hA5);
    tick();

    // Same-address collision in steal: host wins, core retry overwrites
    core_re = 1'b0; core_we = 1'b1; core_addr = 7'd9; core_wdata = 32'h11;
    host_req = 1'b1; host_we = 1'b1; host_addr = 7'd9; host_wdata = 32'h22;
    repeat (4) tick();
    @(negedge clk);
    check_eq("coll_stall", {31'b0, core_stall}, 32'h1);
    tick();
    host_req = 1'b0;
    check_eq("coll_host", mem[9], 32'h22);
    tick();
    check_eq("coll_core", mem[9], 32'h11);
    check_eq("coll_cnt", {16'b0, conflict_cnt}, 32'd8);
    idle_inputs();

    // Host read granted, then reset before the ending edge: rvalid discarded
    host_req = 1'b1; host_we = 1'b0; host_addr = 7'd5;
    @(negedge clk);
    check_eq("rr_gnt", {31'b0, host_gnt}, 32'h1);
    reset = 1'b0;
    idle_inputs();
    tick();
    @(negedge clk);
    check_eq("rr_rvalid", {31'b0, host_rvalid}, 32'h0);
    check_eq("rr_rdata", host_rdata, 32'h0);
    check_eq("rr_gnt0", {31'b0, host_gnt}, 32'h0);
    check_eq("rr_stall", {31'b0, core_stall}, 32'h0);
    check_eq("rr_cnt", {16'b0, conflict_cnt}, 32'h0);
    reset = 1'b1;
    tick();

    // Saturation with STARVE_LIMIT=255: 255 denials + 1 steal per 256 cycles
    s_core_re = 1'b1; s_host_req = 1'b1;
    repeat (300) tick();
    check_eq("sat_partial", {16'b0, s_conflict_cnt}, 32'd299);
    repeat (65500) tick();
    check_eq("sat_full", {16'b0, s_conflict_cnt}, 32'h0000FFFF);
    s_core_re = 1'b0; s_host_req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
